// File: rtl/rgb_pkg.sv
// Shared definitions for the RGB LED path.
// Holds the intensity level width, the number of PWM steps per period, the
// level type used by the colour sequencer and the PWM driver, and the
// brightness-scaling helper used to turn a level into a PWM duty.
package rgb_pkg;

  localparam int LEVEL_W   = 4;
  localparam int PWM_STEPS = 15;

  typedef logic [LEVEL_W-1:0] level_t;

  // Last value of the step counter before it wraps back to 0.
  localparam level_t LAST_STEP = level_t'(PWM_STEPS - 1);

  // duty = floor(level * brightness / 15). The product of two 4-bit values
  // fits in 8 bits, and the quotient never exceeds 15, so it fits a level.
  function automatic level_t scale_level(input level_t level,
                                         input level_t brightness);
    logic [2*LEVEL_W-1:0] prod;
    logic [2*LEVEL_W-1:0] quot;
    prod = level * brightness;
    quot = prod / 8'(PWM_STEPS);
    return quot[LEVEL_W-1:0];
  endfunction

endpackage

// File: rtl/rgb_pwm_driver_pwm_channel.sv
// pwm_channel: one colour channel of the RGB PWM driver.
// Scales the incoming level by the global brightness, holds the result in a
// shadow duty register that only changes when the top level says so, and
// compares it against the shared step counter to produce the LED drive.
//
// Ports:
//   clock       system clock, rising edge
//   reset       asynchronous, active-high; clears the shadow duty
//   load        capture a new duty from level/brightness on this clock
//   run         registered enable from the top level; 0 forces the LED off
//   level       channel intensity, 0 = off, 15 = full
//   brightness  global dimming factor, 15 = unscaled
//   pwm_cnt     shared step counter, 0..14
//   led         LED drive, polarity set by ACTIVE_LOW
module pwm_channel
  import rgb_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic               run,
  input  logic [LEVEL_W-1:0] level,
  input  logic [LEVEL_W-1:0] brightness,
  input  logic [LEVEL_W-1:0] pwm_cnt,
  output logic               led
);

  logic [LEVEL_W-1:0] duty_q;
  logic               on;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      duty_q <= '0;
    end else if (load) begin
      duty_q <= scale_level(level, brightness);
    end
  end

  // Only registered state feeds the output: run, pwm_cnt and duty_q are all
  // flops, so level/brightness changes cannot glitch the LED mid-period.
  // duty 0 never lights; duty 15 lights for all steps 0..14.
  assign on  = run && (pwm_cnt < duty_q);
  assign led = on ^ ACTIVE_LOW;

endmodule

// File: rtl/rgb_pwm_driver.sv
// rgb_pwm_driver: three-channel PWM LED driver with global brightness.
// A shared prescaler divides the clock into PWM steps; a shared step counter
// runs 0..14, giving a period of 15*PRESCALE clocks. Each channel latches its
// scaled duty only at the period wrap (or while idle), so colour updates take
// effect cleanly at the start of a period.
//
// Handshake: there is none; period_start is a one-clock strobe, high in the
// first clock of every period that follows a 14 -> 0 wrap. The first period
// after enable rises (or after reset) starts without a strobe.
//
// Ports:
//   clock         system clock, rising edge
//   reset         asynchronous, active-high
//   enable        1 = run PWM, 0 = hold counters at 0 and force LEDs off
//   r, g, b       channel intensity levels, 0 = off, 15 = full
//   brightness    global dimming, 15 = unscaled, 0 = dark
//   led_r/g/b     LED drives (inverted when ACTIVE_LOW = 1)
//   period_start  registered strobe marking the first clock of a new period
module rgb_pwm_driver
  import rgb_pkg::*;
#(
  parameter int unsigned PRESCALE   = 4,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [LEVEL_W-1:0] r,
  input  logic [LEVEL_W-1:0] g,
  input  logic [LEVEL_W-1:0] b,
  input  logic [LEVEL_W-1:0] brightness,
  output logic               led_r,
  output logic               led_g,
  output logic               led_b,
  output logic               period_start
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0]      presc_q;
  logic [LEVEL_W-1:0] pwm_cnt_q;
  logic               run_q;
  logic               ps_q;

  logic tick;
  logic wrap;
  logic load;

  // run_q is the registered enable. Counting is qualified by it so that the
  // first step after enable rises is a full PRESCALE clocks long, while the
  // enable input itself clears the counters immediately when it drops.
  assign tick = enable && run_q && (presc_q == PRESC_LAST);
  assign wrap = tick && (pwm_cnt_q == LAST_STEP);

  // Duties follow the inputs at every wrap and on every idle clock. The
  // !run_q term also covers the start clock after reset when enable was
  // already high, so that first period uses fresh duties like any restart.
  assign load = wrap || !enable || !run_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc_q   <= '0;
      pwm_cnt_q <= '0;
      run_q     <= 1'b0;
      ps_q      <= 1'b0;
    end else begin
      run_q <= enable;
      ps_q  <= wrap;
      if (!enable) begin
        presc_q   <= '0;
        pwm_cnt_q <= '0;
      end else if (run_q) begin
        if (tick) begin
          presc_q <= '0;
          if (pwm_cnt_q == LAST_STEP) begin
            pwm_cnt_q <= '0;
          end else begin
            pwm_cnt_q <= pwm_cnt_q + 1'b1;
          end
        end else begin
          presc_q <= presc_q + 1'b1;
        end
      end
    end
  end

  assign period_start = ps_q;

  pwm_channel #(.ACTIVE_LOW(ACTIVE_LOW)) u_chan_r (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .run        (run_q),
    .level      (r),
    .brightness (brightness),
    .pwm_cnt    (pwm_cnt_q),
    .led        (led_r)
  );

  pwm_channel #(.ACTIVE_LOW(ACTIVE_LOW)) u_chan_g (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .run        (run_q),
    .level      (g),
    .brightness (brightness),
    .pwm_cnt    (pwm_cnt_q),
    .led        (led_g)
  );

  pwm_channel #(.ACTIVE_LOW(ACTIVE_LOW)) u_chan_b (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .run        (run_q),
    .level      (b),
    .brightness (brightness),
    .pwm_cnt    (pwm_cnt_q),
    .led        (led_b)
  );

endmodule

// File: doc/rgb_pwm_driver.md
RGB_PWM_DRIVER -- requirements
Module: rgb_pwm_driver

Interface
REQ-001 The block SHALL have parameter PRESCALE, default 4, giving clocks per PWM step (legal range 1..65535).
REQ-002 The block SHALL have parameter ACTIVE_LOW, default 0; when 1, all led_* outputs are inverted (on = 0).
REQ-003 Port: clock  input  1  system clock, all state updates on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: enable  input  1  1 = run PWM, 0 = hold counters and force outputs off.
REQ-006 Port: r  input  4  red intensity level from the colour sequencer, 0 = off, 15 = full.
REQ-007 Port: g  input  4  green intensity level, same encoding as r.
REQ-008 Port: b  input  4  blue intensity level, same encoding as r.
REQ-009 Port: brightness  input  4  global dimming factor, 15 = unscaled, 0 = dark.
REQ-010 Port: led_r  output  1  red LED drive.
REQ-011 Port: led_g  output  1  green LED drive.
REQ-012 Port: led_b  output  1  blue LED drive.
REQ-013 Port: period_start  output  1  single-clock pulse marking the clock in which a new PWM period begins.

Function
REQ-014 A prescaler counter SHALL count 0..PRESCALE-1 while enable=1, wrap to 0, and assert an internal tick in the cycle it equals PRESCALE-1.
REQ-015 A step counter pwm_cnt SHALL count 0..14 and advance only on tick, wrapping 14 -> 0; one PWM period = 15*PRESCALE clocks.
REQ-016 Per channel, duty SHALL be floor(level*brightness/15), computed with an 8-bit product and a 4-bit result (range 0..15).
REQ-017 Shadow duty registers SHALL load from the current r/g/b/brightness only on the clock where tick=1 and pwm_cnt=14 (period wrap), or on every clock while enable=0.
REQ-018 Input changes between period wraps SHALL have no effect on outputs until the next wrap (glitch-free colour update).
REQ-019 The on-state of channel x SHALL be (enable=1 AND pwm_cnt < duty_x); duty 0 = never on, duty 15 = on for the whole period.
REQ-020 The led_* outputs SHALL be decoded only from registered state (enable register, pwm_cnt, shadow duty), with no combinational path from r/g/b/brightness.
REQ-021 period_start SHALL be a registered pulse, high for exactly one clock following each 14 -> 0 wrap, and never high while enable=0.
REQ-022 While enable=0, the prescaler and pwm_cnt SHALL be held at 0 and outputs SHALL be inactive.
REQ-023 On enable 0 -> 1, the first period SHALL start at pwm_cnt=0 with the duties loaded on the preceding clock; no period_start pulse is issued for this first period.
REQ-024 With PRESCALE=1, tick SHALL be high on every enabled clock.

Reset
REQ-025 Reset SHALL asynchronously clear the prescaler, pwm_cnt, all shadow duties and period_start to 0.
REQ-026 During reset, all led_* outputs SHALL be at the inactive level (0, or 1 when ACTIVE_LOW=1).
REQ-027 A reset asserted mid-period SHALL abort the period; after release, operation restarts from pwm_cnt=0 as in REQ-023.

Structure
REQ-028 Package rgb_pkg SHALL hold LEVEL_W=4, PWM_STEPS=15 and the level type, shared with the colour sequencer.
REQ-029 Sub-module pwm_channel (duty computation, shadow register, comparator, polarity) SHALL be instantiated three times.
REQ-030 The prescaler and step counter SHALL be shared in the top level, not duplicated per channel.

Verification
REQ-031 PRESCALE=4, brightness=15, r=15, g=0, b=8, enable=1 -> per 60-clock period: led_r high 60, led_g high 0, led_b high 32.
REQ-032 r=15, brightness=8 -> duty 8, led_r high 32 of 60 clocks; brightness=0 -> led_r never high.
REQ-033 r changed from 4 to 12 at pwm_cnt=5 -> current period keeps 16 high clocks; the next period after period_start has 48.
REQ-034 enable dropped mid-period -> all leds inactive the next clock and period_start silent; re-enable -> pwm_cnt restarts at 0.
REQ-035 Reset pulsed at pwm_cnt=7 -> counters and duties at 0 and leds inactive immediately; ACTIVE_LOW=1 run of REQ-031 -> all leds inverted.
